axis_skid_pipeline: RTL and testbench
=====================================

# axis_skid_pipeline

Parametrised AXI-Stream pipeline of N_STAGES full-throughput skid-buffer stages, carrying data, dest, user and tlast. Unlike a plain register chain, every stage honours backpressure: ready is registered per stage, so long ready paths are broken without losing or duplicating beats. It sits on long or congested stream routes between producers and consumers, for timing closure without a separate FIFO.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data field carried.
- DEST_WIDTH, 32, width of dest field carried.
- USER_WIDTH, 32, width of user field carried.
- N_STAGES, 1, number of skid stages; must be ≥1, elaboration error otherwise.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- in  axi_stream.slave  DATA/DEST/USER_WIDTH  upstream stream (valid, ready, data, dest, user, tlast).
- out  axi_stream.master  DATA/DEST/USER_WIDTH  downstream stream.
- occupancy  output  $clog2(2*N_STAGES+1)  beats held in block; present only with AXIS_SKID_PIPELINE_OCCUPANCY_EN.

## Operation
- Each stage k holds a main register (M) and a skid register (S), each with a valid flag; payload = {data, dest, user, tlast}.
- Stage upstream ready = ~S.valid, registered. Stage output valid = M.valid, payload = M. Stage 0 faces `in`; stage N_STAGES-1 drives `out`.
- Per-stage states and transitions (acc = up valid & ready, take = M.valid & down ready):
  - EMPTY: acc → BUSY, M ← input.
  - BUSY: acc & take → BUSY, M ← input; acc & ~take → FULL, S ← input; ~acc & take → EMPTY; else hold.
  - FULL: take → BUSY, M ← S, S cleared; up ready is 0, so no acc.
- Beats leave in arrival order; none dropped or duplicated under any valid/ready pattern.
- Payload is held stable while out.valid=1 and out.ready=0.
- All field widths follow parameters exactly; no truncation or padding inside the block.
- Reset (asynchronous, any time, including mid-packet): all valid flags 0, all payload registers 0, in-flight beats discarded, in.ready 0.
- After reset deassert, an `armed` flop sets on the first clock edge; in.ready = armed & ~S0.valid.

## Timing
- Reset values: out.valid 0, out.data 0, out.dest 0, out.user 0, out.tlast 0, in.ready 0, occupancy 0.
- in.ready rises on the first rising edge after reset deasserts (clock edge with reset=1).
- Latency: beat accepted at edge t appears on out at edge t+N_STAGES when downstream ready is held high.
- Throughput: 1 beat/cycle sustained with out.ready=1.
- Capacity: 2*N_STAGES beats; with out.ready held 0 and in.valid held 1, in.ready falls after exactly 2*N_STAGES accepted beats.
- Ready propagation: out.ready change reaches in.ready no sooner than 1 cycle later (fully registered path; no combinational in→out or out.ready→in.ready path).
- Simultaneous acc and take in a stage: both happen in the same cycle, occupancy unchanged.

## Configuration
- Macro AXIS_SKID_PIPELINE_OCCUPANCY_EN.
- Defined: `occupancy` port exists; registered count of beats in the block, +1 on in accept, −1 on out take, unchanged on both; range 0..2*N_STAGES, reset 0.
- Undefined: port and counter absent; datapath behaviour identical.

## Test plan
- Latency: N_STAGES=3, out.ready=1, single beat data=0xA5A5A5A5, dest=2, user=7, tlast=1 → appears on out exactly 3 cycles after acceptance, all fields intact, valid for 1 cycle.
- Throughput: N_STAGES=2, 100-beat counting stream, out.ready=1 → 100 consecutive out beats 0..99, no bubbles after first, in.ready never drops.
- Fill/backpressure: N_STAGES=4, out.ready=0, in.valid=1 → exactly 8 beats accepted, in.ready=0 thereafter, occupancy=8; release out.ready → beats 0..7 emerge in order, then streaming resumes.
- Random handshake: N_STAGES=5, 10000 beats, random in.valid and out.ready (50%) → scoreboard matches in order, payload stable while stalled, occupancy never exceeds 10.
- Reset mid-operation: fill 5 beats, assert reset asynchronously between edges → out.valid=0, in.ready=0, occupancy=0 immediately; after release in.ready=1 at first edge, no stale beats emerge.
- Width generality: DATA_WIDTH=64, DEST_WIDTH=4, USER_WIDTH=1, data=0xDEADBEEF_CAFEF00D → delivered bit-exact.

Source files
------------

// File: rtl/axis_skid_pipeline.sv
// axis_skid_pipeline: chain of N_STAGES full-throughput skid-buffer stages for an
// AXI-Stream carrying {data, dest, user, tlast}. Every stage registers its upstream
// ready, so the ready path is broken at each stage without losing or duplicating beats.
// Optional feature: define AXIS_SKID_PIPELINE_OCCUPANCY_EN to add the `occupancy` port,
// a registered count of beats currently held in the block.
module axis_skid_pipeline #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 32,
  parameter int unsigned N_STAGES   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  // upstream stream
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic                  in_tlast,
  // downstream stream
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_tlast
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*N_STAGES+1)-1:0] occupancy
`endif
);

  localparam int unsigned PW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,  // main and skid empty
    StBusy  = 2'd1,  // main holds a beat
    StFull  = 2'd2   // main and skid both hold beats
  } stage_state_e;

  if (N_STAGES < 1) begin : g_bad_stages
    $error("axis_skid_pipeline: N_STAGES must be at least 1");
  end

  // Per-stage handshake as seen from the stage's upstream side.
  logic [N_STAGES-1:0]         st_valid;
  logic [N_STAGES-1:0]         st_ready;
  logic [N_STAGES-1:0][PW-1:0] st_pl;

  logic armed_q;

  // Holds in.ready low until the first clock edge after reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic          up_v;
    logic [PW-1:0] up_d;
    logic          dn_r;
    logic          gate;
    logic          acc;
    logic          take;
    logic [PW-1:0] m_q;
    logic [PW-1:0] s_q;
    stage_state_e  state_q;
    stage_state_e  state_d;

    if (k == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = {in_data, in_dest, in_user, in_tlast};
      assign gate = armed_q;
    end else begin : g_mid
      assign up_v = st_valid[k-1];
      assign up_d = st_pl[k-1];
      assign gate = 1'b1;
    end

    if (k == N_STAGES - 1) begin : g_last
      assign dn_r = out_ready;
    end else begin : g_inner
      assign dn_r = st_ready[k+1];
    end

    assign acc  = up_v & st_ready[k];
    assign take = st_valid[k] & dn_r;

    // Stage state register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= StEmpty;
      end else begin
        state_q <= state_d;
      end
    end

    // Next-state: acc fills, take drains; both together keep occupancy steady.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StEmpty: if (acc) state_d = StBusy;
        StBusy: begin
          if (acc && !take) begin
            state_d = StFull;
          end else if (!acc && take) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (take) state_d = StBusy;
        default: state_d = StEmpty;
      endcase
    end

    // Moore outputs: ready and valid come straight from the state register.
    always_comb begin
      st_valid[k] = (state_q != StEmpty);
      st_ready[k] = (state_q != StFull) & gate;
    end

    // Payload registers: main loads from upstream or from skid, skid catches overflow.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        m_q <= '0;
        s_q <= '0;
      end else if (state_q == StFull) begin
        if (take) begin
          m_q <= s_q;
        end
      end else if (acc) begin
        if (state_q == StEmpty || take) begin
          m_q <= up_d;
        end else begin
          s_q <= up_d;
        end
      end
    end

    assign st_pl[k] = m_q;
  end

  assign in_ready  = st_ready[0];
  assign out_valid = st_valid[N_STAGES-1];
  assign {out_data, out_dest, out_user, out_tlast} = st_pl[N_STAGES-1];

`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
  localparam int unsigned OW = $clog2(2*N_STAGES+1);

  logic [OW-1:0] occ_q;
  logic          in_acc;
  logic          out_take;

  assign in_acc   = in_valid & in_ready;
  assign out_take = out_valid & out_ready;

  // Beat count: +1 on accept, -1 on take, unchanged when both happen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      unique case ({in_acc, out_take})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_axis_skid_pipeline.sv
// Scoreboard bench for axis_skid_pipeline (N_STAGES=3, 64/4/3-bit fields).
module tb_axis_skid_pipeline;

  localparam int unsigned NS  = 3;
  localparam int unsigned DW  = 64;
  localparam int unsigned DSW = 4;
  localparam int unsigned UW  = 3;
  localparam int unsigned PW  = DW + DSW + UW + 1;

  typedef logic [PW-1:0] payload_t;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DSW-1:0] in_dest;
  logic [UW-1:0] in_user;
  logic          in_tlast;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DSW-1:0] out_dest;
  logic [UW-1:0] out_user;
  logic          out_tlast;
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
  logic [$clog2(2*NS+1)-1:0] occupancy;
`endif

  payload_t out_pl;
  assign out_pl = {out_data, out_dest, out_user, out_tlast};

  axis_skid_pipeline #(
    .DATA_WIDTH(DW),
    .DEST_WIDTH(DSW),
    .USER_WIDTH(UW),
    .N_STAGES  (NS)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_user  (in_user),
    .in_tlast (in_tlast),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dest (out_dest),
    .out_user (out_user),
    .out_tlast(out_tlast)
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int       n_cmp;
  int       n_err;
  payload_t sb[$];
  int       cyc;
  int       acc_cyc;
  int       take_cyc;
  int       n_acc;
  int       n_take;
  logic     prev_stall;
  payload_t prev_pl;
  payload_t last_pl;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, then wait for the active edge.
  task automatic step(input logic v, input payload_t p, input logic r);
    @(negedge clock);
    in_valid = v;
    {in_data, in_dest, in_user, in_tlast} = p;
    out_ready = r;
    #1;
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
    check("occupancy", occupancy, sb.size());
`endif
    if (prev_stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_payload", out_pl, prev_pl);
    end
    if (in_valid && in_ready) begin
      sb.push_back(p);
      acc_cyc = cyc;
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", out_pl, ~out_pl);
      end else begin
        check("beat", out_pl, sb.pop_front());
      end
      take_cyc = cyc;
      last_pl  = out_pl;
      n_take++;
    end
    prev_stall = out_valid && !out_ready;
    prev_pl    = out_pl;
    @(posedge clock);
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 100) begin
      step(1'b0, '0, 1'b1);
      k++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic payload_t rand_pl();
    payload_t p;
    p[PW-1:PW-32]  = $urandom();
    p[PW-33:PW-64] = $urandom();
    p[7:0]         = 8'($urandom());
    return p;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int guard;
    int t0;
    n_cmp = 0; n_err = 0; cyc = 0; n_acc = 0; n_take = 0;
    acc_cyc = 0; take_cyc = 0; prev_stall = 1'b0; prev_pl = '0; last_pl = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    {in_data, in_dest, in_user, in_tlast} = '0;

    // Asynchronous reset before any clock edge.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_dest", out_dest, '0);
    check("rst_out_user", out_user, '0);
    check("rst_out_tlast", out_tlast, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
    check("rst_occupancy", occupancy, 0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1 check("ready_before_edge", in_ready, 1'b0);
    @(posedge clock);
    #1 check("ready_after_edge", in_ready, 1'b1);

    // Latency: single beat, downstream always ready.
    step(1'b1, {64'h0000_0000_A5A5_A5A5, 4'd2, 3'd7, 1'b1}, 1'b1);
    drain();
    check("lat_cycles", take_cyc - acc_cyc, NS);
    check("lat_payload", last_pl, {64'h0000_0000_A5A5_A5A5, 4'd2, 3'd7, 1'b1});
    @(negedge clock);
    #1 check("lat_one_cycle", out_valid, 1'b0);

    // Throughput: 100-beat counting stream.
    start = cyc;
    t0 = n_take;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, {64'(i), 4'(i), 3'(i), 1'(i == 99)}, 1'b1);
      check("tp_in_ready", in_ready, 1'b1);
    end
    drain();
    check("tp_count", n_take - t0, 100);
    check("tp_no_bubbles", take_cyc - start, 99 + NS);

    // Fill under backpressure: capacity is 2*NS beats.
    t0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, {64'(i), 4'(i), 3'(i), 1'b0}, 1'b0);
    end
    #1;
    check("fill_accepted", n_acc - t0, 2 * NS);
    check("fill_in_ready", in_ready, 1'b0);
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
    check("fill_occupancy", occupancy, 2 * NS);
`endif
    for (int i = 10; i < 20; i++) begin
      step(1'b1, {64'(i), 4'(i), 3'(i), 1'b0}, 1'b1);
    end
    drain();

    // Random valid/ready handshake.
    start = n_acc;
    guard = 0;
    while (n_acc - start < 2000 && guard < 20000) begin
      step(1'($urandom_range(0, 1)), rand_pl(), 1'($urandom_range(0, 1)));
      guard++;
    end
    check("rand_accepted", n_acc - start, 2000);
    drain();

    // Reset asserted between edges with beats in flight.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, {64'(1000 + i), 4'hF, 3'h1, 1'b0}, 1'b0);
    end
    check("mid_fill", sb.size(), 5);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_in_ready", in_ready, 1'b0);
    check("mid_out_data", out_data, '0);
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
    check("mid_occupancy", occupancy, 0);
`endif
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 check("mid_ready_before_edge", in_ready, 1'b0);
    @(posedge clock);
    #1 check("mid_ready_after_edge", in_ready, 1'b1);
    t0 = n_take;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {64'(2000 + i), 4'h3, 3'h2, 1'b1}, 1'b1);
    end
    drain();
    repeat (5) step(1'b0, '0, 1'b1);
    check("mid_no_stale", n_take - t0, 4);

    // Full-width payload delivered bit-exact.
    step(1'b1, {64'hDEAD_BEEF_CAFE_F00D, 4'hA, 3'h5, 1'b1}, 1'b1);
    drain();
    check("wide_data", last_pl[PW-1:8], 64'hDEAD_BEEF_CAFE_F00D);
    check("wide_sideband", last_pl[7:0], {4'hA, 3'h5, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
